// File: rtl/axi_fifo_pkg.sv
// axi_fifo_pkg: shared helpers for the AXI-stream FIFO family.
// Output-stage occupancy encodings: bit 0 = d0 holds a word, bit 1 = d1 holds a word.
package axi_fifo_pkg;

  localparam logic [1:0] OCC_EMPTY = 2'b00;
  localparam logic [1:0] OCC_D0    = 2'b01;
  localparam logic [1:0] OCC_FULL  = 2'b11;

  // Occupancy counters need one extra bit over the RAM address to hold DEPTH and above.
  function automatic int unsigned cnt_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/axi_fifo_out_stage.sv
// axi_fifo_out_stage: two-register (d0 -> d1) output pipeline with ready/valid on both sides.
// d1 drives the consumer; d0 lets the upstream read issue while d1 is stalled.
module axi_fifo_out_stage
  import axi_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occ_next
);

  logic [1:0]       occ_q, occ_d;
  logic [WIDTH-1:0] d0_q, d1_q;
  logic             d1_adv, in_fire;

  assign d1_adv    = out_ready | ~occ_q[1];
  assign in_ready  = (occ_q != OCC_FULL) | out_ready;
  assign in_fire   = in_valid & in_ready;
  assign out_valid = occ_q[1];
  assign out_data  = d1_q;
  assign occ_next  = occ_d;

  // Next occupancy: d0 shifts into d1 when d1 advances, then a new read refills d0.
  always_comb begin
    occ_d = occ_q;
    if (d1_adv) begin
      occ_d = {occ_q[0], 1'b0};
    end
    if (in_fire) begin
      occ_d = occ_d | OCC_D0;
    end
  end

  // Pipeline registers; d1 only changes when it is empty or being consumed.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      occ_q <= OCC_EMPTY;
      d0_q  <= '0;
      d1_q  <= '0;
    end else begin
      occ_q <= occ_d;
      if (in_fire) begin
        d0_q <= in_data;
      end
      if (d1_adv && occ_q[0]) begin
        d1_q <= d0_q;
      end
    end
  end

endmodule

// File: rtl/axi_fifo_pkt.sv
// axi_fifo_pkt: AXI-stream FIFO carrying tdata + tlast, with registered fill count and
// runtime-programmable almost-full / almost-empty flags.
// Optional packet mode: define AXI_FIFO_PKT_MODE_EN to release RAM words only once a whole
// packet (tlast) is stored, or when the RAM is full so oversize packets cannot deadlock.
module axi_fifo_pkt
  import axi_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter string       RAM_STYLE  = "distributed"
) (
  input  logic                  clk,
  input  logic                  sync_reset,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic [ADDR_WIDTH:0]   ae_thresh,
  output logic [ADDR_WIDTH:0]   data_cnt,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CntW  = cnt_width(ADDR_WIDTH);
  localparam int unsigned SumW  = CntW + 1;
  localparam int unsigned WordW = DATA_WIDTH + 1;

  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                  full, empty, wr_en, rd_en, rd_allow, stage_ready;
  logic [WordW-1:0]      rd_word, out_word;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [1:0]            occ_next;
  logic [ADDR_WIDTH:0]   ram_cnt_d;
  logic [SumW-1:0]       cnt_sum;
  logic [CntW-1:0]       cnt_d, cnt_q;
  logic                  af_q, ae_q;

  // Full/empty from registered pointers only, so a read never lets a write fall through.
  always_comb begin
    full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
            (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    empty = (wr_ptr_q == rd_ptr_q);
  end

  assign s_axis_tready = ~full;
  assign wr_en         = s_axis_tvalid & ~full;
  assign rd_en         = rd_allow & stage_ready;
  assign wr_ptr_d      = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, wr_en};
  assign rd_ptr_d      = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, rd_en};
  assign wr_addr       = wr_ptr_q[ADDR_WIDTH-1:0];
  assign rd_addr       = rd_ptr_q[ADDR_WIDTH-1:0];

  // Storage word is {tlast, tdata}; contents survive reset, only the pointers are cleared.
  if (RAM_STYLE == "block") begin : g_ram_block
    (* ram_style = "block" *) logic [WordW-1:0] mem [DEPTH];
    // RAM write port.
    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem[wr_addr] <= {s_axis_tlast, s_axis_tdata};
      end
    end
    assign rd_word = mem[rd_addr];
  end else begin : g_ram_dist
    (* ram_style = "distributed" *) logic [WordW-1:0] mem [DEPTH];
    // RAM write port.
    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem[wr_addr] <= {s_axis_tlast, s_axis_tdata};
      end
    end
    assign rd_word = mem[rd_addr];
  end

`ifdef AXI_FIFO_PKT_MODE_EN
  logic [CntW-1:0] pkt_cnt_q;
  logic            pkt_inc, pkt_dec;

  assign pkt_inc  = wr_en & s_axis_tlast;
  assign pkt_dec  = rd_en & rd_word[DATA_WIDTH];
  assign rd_allow = ~empty & ((pkt_cnt_q != '0) | full);

  // Complete packets resident in RAM; simultaneous inc and dec cancel.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      pkt_cnt_q <= '0;
    end else if (pkt_inc && !pkt_dec) begin
      pkt_cnt_q <= pkt_cnt_q + CntW'(1);
    end else if (pkt_dec && !pkt_inc) begin
      pkt_cnt_q <= pkt_cnt_q - CntW'(1);
    end
  end
`else
  assign rd_allow = ~empty;
`endif

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  axi_fifo_out_stage #(
    .WIDTH (WordW)
  ) u_out_stage (
    .clk        (clk),
    .sync_reset (sync_reset),
    .in_valid   (rd_allow),
    .in_ready   (stage_ready),
    .in_data    (rd_word),
    .out_valid  (m_axis_tvalid),
    .out_ready  (m_axis_tready),
    .out_data   (out_word),
    .occ_next   (occ_next)
  );

  assign m_axis_tdata = out_word[DATA_WIDTH-1:0];
  assign m_axis_tlast = out_word[DATA_WIDTH];

  // Occupancy of RAM plus output stages after this edge, saturated to the counter width.
  always_comb begin
    ram_cnt_d = wr_ptr_d - rd_ptr_d;
    cnt_sum   = SumW'(ram_cnt_d) + SumW'(occ_next[0]) + SumW'(occ_next[1]);
    cnt_d     = cnt_sum[SumW-1] ? '1 : cnt_sum[CntW-1:0];
  end

  // Fill count register; flags compare the registered count, adding one more cycle of lag.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      cnt_q <= '0;
      af_q  <= (af_thresh == '0);
      ae_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      af_q  <= (cnt_q >= af_thresh);
      ae_q  <= (cnt_q <= ae_thresh);
    end
  end

  assign data_cnt     = cnt_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;

endmodule

// File: tb/tb_axi_fifo_pkt.sv
// tb_axi_fifo_pkt: directed self-checking bench for axi_fifo_pkt at ADDR_WIDTH=4 (DEPTH=16).
module tb_axi_fifo_pkt;

  logic        clk = 1'b0;
  logic        sync_reset;
  logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [31:0] s_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [4:0]  af_thresh, ae_thresh, data_cnt;
  logic        almost_full, almost_empty;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;
  int acc;

  always #5 clk = ~clk;

  axi_fifo_pkt #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (4),
    .RAM_STYLE  ("distributed")
  ) dut (
    .clk           (clk),
    .sync_reset    (sync_reset),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .af_thresh     (af_thresh),
    .ae_thresh     (ae_thresh),
    .data_cnt      (data_cnt),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push n words through with a queue scoreboard; rnd randomises both valid and ready.
  task automatic stream(input int n, input bit rnd, input bit last_only);
    logic [32:0] q[$];
    logic [32:0] prev_out;
    logic [32:0] exp_word;
    bit          prev_stall = 0;
    bit          took;
    int          sent = 0, got = 0, cyc = 0;
    s_axis_tvalid = 1'b0;
    while ((sent < n || got < n) && cyc < 20000) begin
      if (!s_axis_tvalid && sent < n && (!rnd || $urandom_range(0, 3) != 0)) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = $urandom;
        s_axis_tlast  = last_only ? (sent == n - 1) : ((sent % 5 == 4) || (sent == n - 1));
      end
      m_axis_tready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (prev_stall) begin
        check("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, prev_out});
      end
      took = s_axis_tvalid && s_axis_tready;
      if (took) begin
        q.push_back({s_axis_tlast, s_axis_tdata});
        sent++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        exp_word = (q.size() != 0) ? q.pop_front() : 33'h0;
        check("stream_word", {m_axis_tlast, m_axis_tdata}, exp_word);
        got++;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_out   = {m_axis_tlast, m_axis_tdata};
      tick();
      cyc++;
      if (took) s_axis_tvalid = 1'b0;
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    check("stream_sent", sent, n);
    check("stream_got", got, n);
    tick();
    tick();
    check("stream_cnt_zero", data_cnt, 0);
  endtask

  initial begin
    sync_reset    = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;
    af_thresh     = 5'd0;
    ae_thresh     = 5'd2;

    // Reset state, with af_thresh = 0 forcing almost_full.
    tick();
    tick();
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tready", s_axis_tready, 1);
    check("rst_cnt", data_cnt, 0);
    check("rst_ae", almost_empty, 1);
    check("rst_af_thresh0", almost_full, 1);
    af_thresh = 5'd12;
    tick();
    check("rst_af_thresh12", almost_full, 0);
    sync_reset = 1'b0;
    tick();
    check("idle_cnt", data_cnt, 0);

    // Single word latency: valid after E+2, count 0 -> 1 -> 0.
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'hA5A5_A5A5;
    s_axis_tlast  = 1'b1;
    tick();
    s_axis_tvalid = 1'b0;
    check("lat_e0_valid", m_axis_tvalid, 0);
    check("lat_e0_cnt", data_cnt, 1);
    tick();
    check("lat_e1_valid", m_axis_tvalid, 0);
    tick();
    check("lat_e2_valid", m_axis_tvalid, 1);
    check("lat_e2_data", m_axis_tdata, 32'hA5A5_A5A5);
    check("lat_e2_last", m_axis_tlast, 1);
    check("lat_e2_cnt", data_cnt, 1);
    tick();
    check("lat_e3_valid", m_axis_tvalid, 0);
    check("lat_e3_cnt", data_cnt, 0);
    tick();
    tick();

    // Fill with consumer stalled: 18 accepted, flags lag two cycles.
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b1;
    acc = 0;
    for (int n = 1; n <= 22; n++) begin
      s_axis_tdata = 32'h100 + acc;
      s_axis_tlast = 1'b1;
      if (s_axis_tready) acc++;
      tick();
      if (n == 3)  check("ae_after_e3", almost_empty, 1);
      if (n == 4)  check("ae_after_e4", almost_empty, 0);
      if (n == 12) check("af_after_e12", almost_full, 0);
      if (n == 13) check("af_after_e13", almost_full, 1);
    end
    s_axis_tvalid = 1'b0;
    check("fill_accepted", acc, 18);
    check("fill_cnt", data_cnt, 18);
    check("fill_tready", s_axis_tready, 0);
    check("fill_head", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {2'b11, 32'h100});

    // Drain 11 at full rate, leaving 7 stored.
    m_axis_tready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      check("drain_word", {m_axis_tvalid, m_axis_tdata}, {1'b1, 32'h100 + i});
      tick();
    end
    m_axis_tready = 1'b0;
    tick();
    check("drain_cnt7", data_cnt, 7);
    check("drain_hold", m_axis_tdata, 32'h10B);

    // Mid-stream reset discards the 7 stored words.
    sync_reset = 1'b1;
    tick();
    sync_reset = 1'b0;
    check("mrst_tvalid", m_axis_tvalid, 0);
    check("mrst_cnt", data_cnt, 0);
    check("mrst_tready", s_axis_tready, 1);
    check("mrst_ae", almost_empty, 1);
    check("mrst_af", almost_full, 0);
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'hBEEF_0001;
    s_axis_tlast  = 1'b1;
    tick();
    s_axis_tvalid = 1'b0;
    check("fresh_cnt", data_cnt, 1);
    tick();
    tick();
    check("fresh_word", {m_axis_tvalid, m_axis_tdata}, {1'b1, 32'hBEEF_0001});
    tick();
    check("fresh_gone", m_axis_tvalid, 0);

    // Random valid/ready streaming.
    stream(300, 1'b1, 1'b0);

`ifdef AXI_FIFO_PKT_MODE_EN
    // Packet mode: output held until the tlast word is stored.
    m_axis_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'hC000_0000 + i;
      s_axis_tlast  = (i == 4);
      tick();
      s_axis_tvalid = 1'b0;
      check("pkt_wait", m_axis_tvalid, 0);
      if (i < 4) begin
        tick();
        check("pkt_gap1", m_axis_tvalid, 0);
        tick();
        check("pkt_gap2", m_axis_tvalid, 0);
      end
    end
    tick();
    check("pkt_e1", m_axis_tvalid, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("pkt_out", {m_axis_tvalid, m_axis_tlast, m_axis_tdata},
            {1'b1, (i == 4), 32'hC000_0000 + i});
      tick();
    end
    check("pkt_done", m_axis_tvalid, 0);
    // Oversize packet must drain once the RAM is full.
    stream(20, 1'b0, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
